// File: rtl/tinyml_display_stream_packer_pkg.sv
// ----------------------------------------------------------------------------
// tinyml_display_stream_packer_pkg
//
// Purpose : Definitions shared by the display stream packer and the annotator
//           that consumes its packets: packet type codes, packer FSM states,
//           header field positions, the pad word and a header builder.
//
// Contents:
//   pkt_type_e   - 3-bit packet type code carried in header bits [2:0]
//   state_e      - packer FSM states
//   HDR_*        - header field offsets and widths
//   CNT_W/SEQ_W  - payload counter and sequence number widths
//   PAD_WORD     - value of the trailing pad word
//   make_header  - assembles a header word from a type and a sequence number
// ----------------------------------------------------------------------------
package tinyml_display_stream_packer_pkg;

    // Codes shared with the annotator. Only IMAGE and BBOX are produced by
    // the packer; the others are decoded downstream and never emitted here.
    typedef enum logic [2:0] {
        PKT_IDLE  = 3'd0,
        PKT_IMAGE = 3'd1,
        PKT_BBOX  = 3'd2,
        PKT_LOGO  = 3'd3,
        PKT_SKIP  = 3'd4
    } pkt_type_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_PAD     = 2'd2
    } state_e;

    localparam int HDR_TYPE_LSB = 0;
    localparam int HDR_TYPE_W   = 3;
    localparam int HDR_SEQ_LSB  = 16;
    localparam int HDR_SEQ_W    = 16;

    localparam int CNT_W = 20;
    localparam int SEQ_W = HDR_SEQ_W;

    localparam logic [63:0] PAD_WORD = 64'h0;

    // Every field outside type and seq is zero.
    function automatic logic [63:0] make_header(input pkt_type_e  pkt_type,
                                                input logic [SEQ_W-1:0] seq);
        logic [63:0] hdr;
        hdr = '0;
        hdr[HDR_TYPE_LSB +: HDR_TYPE_W] = pkt_type;
        hdr[HDR_SEQ_LSB  +: HDR_SEQ_W]  = seq;
        return hdr;
    endfunction

endpackage

// File: rtl/tinyml_display_stream_packer.sv
// ----------------------------------------------------------------------------
// tinyml_display_stream_packer
//
// Purpose : Transmit-side packetizer for the display annotation stream.
//           Builds typed packets from two independent 64-bit sources (image
//           pixels, 2 per word, and bounding-box records). Each packet is
//           one header word, N payload words and one zero pad word, so the
//           word count stays even for the 128-bit DMA interconnect.
//
// Parameters:
//   FRAME_WIDTH, FRAME_HEIGHT - image size in pixels
//   MAX_BBOX                  - bbox words per bbox packet
//   IMG_DATA_COUNT            - derived image payload length (W*H/2)
//
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   img_valid/img_data/img_ready   - image source (valid/ready)
//   bbox_valid/bbox_data/bbox_ready- bbox source (valid/ready)
//   out_valid/out_data/out_last    - registered packet output, last = pad word
//   out_ready                      - downstream accept
// ----------------------------------------------------------------------------
module tinyml_display_stream_packer
    import tinyml_display_stream_packer_pkg::*;
#(
    parameter int FRAME_WIDTH  = 540,
    parameter int FRAME_HEIGHT = 540,
    parameter int MAX_BBOX     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        img_valid,
    input  logic [63:0] img_data,
    output logic        img_ready,
    input  logic        bbox_valid,
    input  logic [63:0] bbox_data,
    output logic        bbox_ready,
    output logic        out_valid,
    output logic [63:0] out_data,
    output logic        out_last,
    input  logic        out_ready
);

    localparam int IMG_DATA_COUNT = (FRAME_WIDTH * FRAME_HEIGHT) / 2;

    // Packets must have an even word count and fit the payload counter.
    if ((IMG_DATA_COUNT % 2) != 0) begin : g_err_img_odd
        $error("IMG_DATA_COUNT must be even");
    end
    if ((MAX_BBOX % 2) != 0) begin : g_err_bbox_odd
        $error("MAX_BBOX must be even");
    end
    if (IMG_DATA_COUNT > (2 ** CNT_W)) begin : g_err_img_big
        $error("IMG_DATA_COUNT exceeds the payload counter range");
    end
    if (MAX_BBOX > (2 ** CNT_W)) begin : g_err_bbox_big
        $error("MAX_BBOX exceeds the payload counter range");
    end
    if ((IMG_DATA_COUNT < 2) || (MAX_BBOX < 2)) begin : g_err_empty
        $error("payload lengths must be at least 2");
    end

    localparam logic [CNT_W-1:0] IMG_LAST  = CNT_W'(IMG_DATA_COUNT - 1);
    localparam logic [CNT_W-1:0] BBOX_LAST = CNT_W'(MAX_BBOX - 1);

    state_e             state_q,     state_d;
    pkt_type_e          sel_q,       sel_d;
    pkt_type_e          last_type_q, last_type_d;
    logic               sent_any_q,  sent_any_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [SEQ_W-1:0]   seq_q,       seq_d;
    logic               out_valid_q, out_valid_d;
    logic [63:0]        out_data_q,  out_data_d;
    logic               out_last_q,  out_last_d;

    logic               adv;
    logic               in_payload;
    logic               src_valid;
    logic [63:0]        src_data;
    logic [CNT_W-1:0]   pay_last;

    // The output register may take a new word when it is empty or being
    // drained this cycle.
    assign adv        = ~out_valid_q | out_ready;
    assign in_payload = (state_q == S_PAYLOAD);

    always_comb begin
        src_valid = img_valid;
        src_data  = img_data;
        pay_last  = IMG_LAST;
        if (sel_q == PKT_BBOX) begin
            src_valid = bbox_valid;
            src_data  = bbox_data;
            pay_last  = BBOX_LAST;
        end
    end

    // Only the selected source is ever offered a handshake, and only while
    // the payload is being streamed.
    assign img_ready  = in_payload & (sel_q == PKT_IMAGE) & adv;
    assign bbox_ready = in_payload & (sel_q == PKT_BBOX)  & adv;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_type_d = last_type_q;
        sent_any_d  = sent_any_q;
        cnt_d       = cnt_q;
        seq_d       = seq_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        case (state_q)
            S_IDLE: begin
                if (adv) begin
                    if (img_valid | bbox_valid) begin
                        // Round-robin on contention. Until a packet has been
                        // completed there is no previous type, so the image
                        // stream takes precedence on the very first packet.
                        if (img_valid & bbox_valid) begin
                            if (sent_any_q && (last_type_q == PKT_IMAGE)) begin
                                sel_d = PKT_BBOX;
                            end else begin
                                sel_d = PKT_IMAGE;
                            end
                        end else if (img_valid) begin
                            sel_d = PKT_IMAGE;
                        end else begin
                            sel_d = PKT_BBOX;
                        end
                        out_valid_d = 1'b1;
                        out_data_d  = make_header(sel_d, seq_q);
                        out_last_d  = 1'b0;
                        cnt_d       = '0;
                        state_d     = S_PAYLOAD;
                    end else begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end
                end
            end

            S_PAYLOAD: begin
                if (adv) begin
                    if (src_valid) begin
                        out_valid_d = 1'b1;
                        out_data_d  = src_data;
                        out_last_d  = 1'b0;
                        cnt_d       = cnt_q + 1'b1;
                        if (cnt_q == pay_last) begin
                            state_d = S_PAD;
                        end
                    end else begin
                        // Source stall: emit a bubble, keep the packet open.
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end
                end
            end

            S_PAD: begin
                if (adv) begin
                    out_valid_d = 1'b1;
                    out_data_d  = PAD_WORD;
                    out_last_d  = 1'b1;
                    last_type_d = sel_q;
                    sent_any_d  = 1'b1;
                    seq_d       = seq_q + 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sel_q       <= PKT_IMAGE;
            last_type_q <= PKT_IMAGE;
            sent_any_q  <= 1'b0;
            cnt_q       <= '0;
            seq_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_type_q <= last_type_d;
            sent_any_q  <= sent_any_d;
            cnt_q       <= cnt_d;
            seq_q       <= seq_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_tinyml_display_stream_packer.sv
// ----------------------------------------------------------------------------
// tb_tinyml_display_stream_packer
//
// Scoreboard bench on a small configuration (4x4 frame -> 8 image words,
// 4 bbox words). Expected packets are produced by a packet-level model and
// queued when stimulus is issued; a monitor pops and compares every output
// handshake.
// ----------------------------------------------------------------------------
module tb_tinyml_display_stream_packer;

    localparam int N_IMG  = 8;
    localparam int N_BBOX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        img_valid = 1'b0;
    logic [63:0] img_data = '0;
    logic        img_ready;
    logic        bbox_valid = 1'b0;
    logic [63:0] bbox_data = '0;
    logic        bbox_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_last;
    logic        out_ready = 1'b1;

    always #5 clk = ~clk;

    tinyml_display_stream_packer #(
        .FRAME_WIDTH (4),
        .FRAME_HEIGHT(4),
        .MAX_BBOX    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .img_valid (img_valid),
        .img_data  (img_data),
        .img_ready (img_ready),
        .bbox_valid(bbox_valid),
        .bbox_data (bbox_data),
        .bbox_ready(bbox_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] img_src_q[$];
    logic [63:0] bbox_src_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int bp_pct   = 0;

    // Packet-level reference state
    int m_seq      = 0;
    bit m_first    = 1'b1;
    bit m_last_img = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] hdr_word(input bit is_img, input int seq);
        return (64'(seq) << 16) | (is_img ? 64'd1 : 64'd2);
    endfunction

    task automatic model_reset();
        m_seq   = 0;
        m_first = 1'b1;
    endtask

    task automatic model_words(input bit is_img, input int n);
        logic [63:0] w;
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            if (is_img) img_src_q.push_back(w);
            else        bbox_src_q.push_back(w);
            exp_q.push_back('{w, 1'b0});
        end
    endtask

    task automatic model_packet(input bit is_img);
        exp_q.push_back('{hdr_word(is_img, m_seq), 1'b0});
        model_words(is_img, is_img ? N_IMG : N_BBOX);
        exp_q.push_back('{64'd0, 1'b1});
        m_seq      = (m_seq + 1) % 65536;
        m_first    = 1'b0;
        m_last_img = is_img;
    endtask

    // Both sources hold a packet ready whenever they have one queued, so a
    // contended choice is the type not sent last (image when none sent yet).
    task automatic model_phase(input int ni, input int nb);
        bit pick_img;
        while (ni > 0 || nb > 0) begin
            if (ni > 0 && nb > 0) pick_img = m_first ? 1'b1 : !m_last_img;
            else                  pick_img = (ni > 0);
            model_packet(pick_img);
            if (pick_img) ni--;
            else          nb--;
        end
    endtask

    // ---------------- source drivers ----------------
    task automatic set_src(input bit is_img, input bit v, input logic [63:0] w);
        if (is_img) begin img_valid = v; img_data = w; end
        else        begin bbox_valid = v; bbox_data = w; end
    endtask

    // Drains the source queue. Random gaps only occur inside a payload, so
    // the first word of each packet is offered without delay.
    task automatic drive(input bit is_img, input int gap_pct, input int gap_at, input int gap_len);
        int          n;
        int          i;
        int          k;
        bit          hs;
        logic [63:0] w;
        n = is_img ? N_IMG : N_BBOX;
        i = 0;
        @(posedge clk); #1;
        while (is_img ? (img_src_q.size() > 0) : (bbox_src_q.size() > 0)) begin
            if (is_img) w = img_src_q.pop_front();
            else        w = bbox_src_q.pop_front();
            k = i % n;
            if (k != 0 && gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                set_src(is_img, 1'b0, w);
                repeat ($urandom_range(3, 1)) begin @(posedge clk); #1; end
            end
            if (k == gap_at && gap_len >= 3) begin
                set_src(is_img, 1'b0, w);
                repeat (2) begin @(posedge clk); #1; end
                @(negedge clk);
                check("gap_out_valid", 64'(out_valid), 64'd0);
                @(posedge clk); #1;
                repeat (gap_len - 3) begin @(posedge clk); #1; end
            end
            set_src(is_img, 1'b1, w);
            hs = 1'b0;
            while (!hs) begin
                @(negedge clk);
                hs = is_img ? img_ready : bbox_ready;
                @(posedge clk); #1;
            end
            i++;
        end
        set_src(is_img, 1'b0, 64'd0);
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while (exp_q.size() > 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d words still expected, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- downstream backpressure ----------------
    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = (bp_pct == 0) ? 1'b1 : ($urandom_range(99) >= bp_pct);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit          stall_chk;
        logic [63:0] st_data;
        logic        st_last;
        exp_t        e;
        stall_chk = 1'b0;
        st_data   = '0;
        st_last   = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_chk) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", out_data, st_data);
                check("stall_last", 64'(out_last), 64'(st_last));
                stall_chk = 1'b0;
            end
            if (img_ready || bbox_ready)
                check("ready_exclusive", 64'(img_ready & bbox_ready), 64'd0);
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: got %h last=%0b, required no word", out_data, out_last);
                    end else begin
                        e = exp_q.pop_front();
                        $display("word data=%h last=%0b exp=%h/%0b", out_data, out_last, e.data, e.last);
                        check("out_data", out_data, e.data);
                        check("out_last", 64'(out_last), 64'(e.last));
                    end
                end else if (!rst) begin
                    stall_chk = 1'b1;
                    st_data   = out_data;
                    st_last   = out_last;
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        repeat (60000) @(posedge clk);
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] w;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_img_ready", 64'(img_ready), 64'd0);
        check("rst_bbox_ready", 64'(bbox_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // Image only, no backpressure: two packets, seq 0 then 1
        model_phase(2, 0);
        drive(1'b1, 0, -1, 0);
        wait_drain(200);

        // Both sources valid from reset: IMAGE, BBOX, IMAGE, BBOX
        do_reset();
        model_reset();
        model_phase(2, 2);
        fork
            drive(1'b1, 0, -1, 0);
            drive(1'b0, 0, -1, 0);
        join
        wait_drain(200);

        // Random source gaps and 50% downstream backpressure
        do_reset();
        model_reset();
        bp_pct = 50;
        model_phase(3, 3);
        fork
            drive(1'b1, 30, -1, 0);
            drive(1'b0, 30, -1, 0);
        join
        wait_drain(2000);
        bp_pct = 0;

        // Five-cycle image stall before payload word 4
        model_phase(1, 0);
        drive(1'b1, 0, 4, 5);
        wait_drain(200);

        // Reset while payload word 3 is offered: packet truncated, no pad
        exp_q.push_back('{hdr_word(1'b1, m_seq), 1'b0});
        model_words(1'b1, 3);
        drive(1'b1, 0, -1, 0);
        w = {$urandom, $urandom};
        img_data  = w;
        img_valid = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_last", 64'(out_last), 64'd0);
        check("midrst_img_ready", 64'(img_ready), 64'd0);
        check("midrst_bbox_ready", 64'(bbox_ready), 64'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        img_valid = 1'b0;
        model_reset();
        model_phase(1, 0);
        drive(1'b1, 0, -1, 0);
        wait_drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
